// File: rtl/vita49_trig_logic.sv
// Timed-start gate: opens samp_en when the registered TSF reaches the programmed trigger time.
// Optional build macro VITA49_TRIG_LATE_START_EN lets a late trigger fire instead of going to DONE.

module vita49_trig_logic #(
    parameter int CNT_W = 32
) (
    input  logic             samp_clk,
    input  logic             RESET,
    input  logic [63:0]      tsf,
    input  logic             in_valid,
    input  logic [31:0]      ctrl,
    input  logic [31:0]      trig_ts_hi,
    input  logic [31:0]      trig_ts_lo,
    input  logic [CNT_W-1:0] burst_len,
    output logic             samp_en,
    output logic             trig_pulse,
    output logic [31:0]      status,
    output logic [CNT_W-1:0] samples_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       ctrl_p1;
    logic             arm_prev_p1;
    logic [63:0]      tsf_p1;
    logic [63:0]      trig_time;
    logic [CNT_W-1:0] cnt;
    logic             late_q;
    logic             done_q;
    logic             cont_q;
    logic             first_cmp_p1;
    logic             trig_pulse_p1;

    logic             arm_edge;
    logic             abort;
    logic             arm_take;
    logic             fire;
    logic             late_set;
    logic             done_set;
    logic             dec;
    logic             ctrl_unused;

    assign ctrl_unused = ^ctrl[31:3];
    assign arm_edge    = ctrl_p1[0] & ~arm_prev_p1;
    assign abort       = ctrl_p1[1];

    always_ff @(posedge samp_clk or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort wins over everything; the late test only applies on the first ARMED cycle.
    always_comb begin
        state_nxt = state;
        arm_take  = 1'b0;
        fire      = 1'b0;
        late_set  = 1'b0;
        done_set  = 1'b0;
        dec       = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm_edge) begin
                        arm_take  = 1'b1;
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (first_cmp_p1 && (tsf_p1 > trig_time)) begin
                        late_set = 1'b1;
`ifdef VITA49_TRIG_LATE_START_EN
                        fire     = 1'b1;
`else
                        state_nxt = DONE;
`endif
                    end else if (tsf_p1 >= trig_time) begin
                        fire = 1'b1;
                    end
                    if (fire) begin
                        if ((cnt == '0) && !cont_q) begin
                            state_nxt = DONE;
                            done_set  = 1'b1;
                        end else begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    if (!cont_q && in_valid && (cnt != '0)) begin
                        dec = 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state_nxt = DONE;
                            done_set  = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---- p1: registered ctrl / tsf, latched arm parameters, burst counter ----
    always_ff @(posedge samp_clk or posedge RESET) begin
        if (RESET) begin
            ctrl_p1       <= '0;
            arm_prev_p1   <= 1'b0;
            tsf_p1        <= '0;
            trig_time     <= '0;
            cnt           <= '0;
            late_q        <= 1'b0;
            done_q        <= 1'b0;
            cont_q        <= 1'b0;
            first_cmp_p1  <= 1'b0;
            trig_pulse_p1 <= 1'b0;
        end else begin
            ctrl_p1       <= ctrl[2:0];
            arm_prev_p1   <= ctrl_p1[0];
            tsf_p1        <= tsf;
            first_cmp_p1  <= arm_take;
            trig_pulse_p1 <= fire;
            if (arm_take) begin
                trig_time <= {trig_ts_hi, trig_ts_lo};
                cnt       <= burst_len;
                late_q    <= 1'b0;
                done_q    <= 1'b0;
                cont_q    <= ctrl_p1[2];
            end else begin
                if (dec) begin
                    cnt <= cnt - CNT_W'(1);
                end
                if (late_set) begin
                    late_q <= 1'b1;
                end
                if (done_set) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        samp_en      = (state == RUN);
        trig_pulse   = trig_pulse_p1;
        status       = {28'd0, done_q, late_q, state};
        samples_left = cnt;
    end

endmodule

// File: tb/tb_vita49_trig_logic.sv
// Directed bench for vita49_trig_logic with a per-cycle reference model.

module tb_vita49_trig_logic;

    localparam int CNT_W = 32;

    logic             samp_clk = 1'b0;
    logic             RESET;
    logic [63:0]      tsf;
    logic             in_valid;
    logic [31:0]      ctrl;
    logic [31:0]      trig_ts_hi;
    logic [31:0]      trig_ts_lo;
    logic [CNT_W-1:0] burst_len;
    logic             samp_en;
    logic             trig_pulse;
    logic [31:0]      status;
    logic [CNT_W-1:0] samples_left;

    int total = 0;
    int bad   = 0;
    bit tsf_run;

    // reference model: phase 0 idle, 1 waiting for time, 2 bursting, 3 finished
    int          m_ph;
    bit          m_late, m_done, m_cont, m_first, m_pulse;
    longint      m_rem;
    logic [63:0] m_tt;
    logic [63:0] t1;
    logic [2:0]  c1, c2;

    vita49_trig_logic #(.CNT_W(CNT_W)) dut (
        .samp_clk     (samp_clk),
        .RESET        (RESET),
        .tsf          (tsf),
        .in_valid     (in_valid),
        .ctrl         (ctrl),
        .trig_ts_hi   (trig_ts_hi),
        .trig_ts_lo   (trig_ts_lo),
        .burst_len    (burst_len),
        .samp_en      (samp_en),
        .trig_pulse   (trig_pulse),
        .status       (status),
        .samples_left (samples_left)
    );

    always #5 samp_clk = ~samp_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        bit arm, was_first, go;
        if (RESET) begin
            m_ph = 0; m_late = 0; m_done = 0; m_cont = 0; m_first = 0; m_pulse = 0;
            m_rem = 0; m_tt = '0; t1 = '0; c1 = '0; c2 = '0;
            return;
        end
        arm       = c1[0] && !c2[0];
        was_first = m_first;
        m_first   = 0;
        m_pulse   = 0;
        if (c1[1]) begin
            m_ph = 0;
        end else if ((m_ph == 0 || m_ph == 3) && arm) begin
            m_ph    = 1;
            m_tt    = {trig_ts_hi, trig_ts_lo};
            m_rem   = longint'(burst_len);
            m_late  = 0;
            m_done  = 0;
            m_cont  = c1[2];
            m_first = 1;
        end else if (m_ph == 1) begin
            go = (t1 >= m_tt);
            if (was_first && t1 > m_tt) begin
                m_late = 1;
`ifdef VITA49_TRIG_LATE_START_EN
                go = 1;
`else
                go   = 0;
                m_ph = 3;
`endif
            end
            if (go) begin
                m_pulse = 1;
                if (m_rem == 0 && !m_cont) begin
                    m_ph   = 3;
                    m_done = 1;
                end else begin
                    m_ph = 2;
                end
            end
        end else if (m_ph == 2 && !m_cont && in_valid && m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_ph   = 3;
                m_done = 1;
            end
        end
        c2 = c1;
        c1 = ctrl[2:0];
        t1 = tsf;
    endtask

    task automatic tick();
        @(posedge samp_clk);
        model_step();
        #2;
        chk("m_samp_en", samp_en, (m_ph == 2));
        chk("m_trig_pulse", trig_pulse, m_pulse);
        chk("m_status", status, {28'd0, m_done, m_late, m_ph[1:0]});
        chk("m_samples_left", samples_left, m_rem[31:0]);
        if (tsf_run) tsf = tsf + 64'd1;
    endtask

    task automatic arm(input logic [63:0] tt, input int len, input bit cont);
        trig_ts_hi = tt[63:32];
        trig_ts_lo = tt[31:0];
        burst_len  = len;
        ctrl       = {29'd0, cont, 1'b0, 1'b1};
        tick();
        tick();
        ctrl = '0;
    endtask

    task automatic wait_pulse(input int budget, output bit found);
        int i;
        found = 0;
        i = 0;
        while (!found && i < budget) begin
            if (trig_pulse) found = 1;
            else begin
                tick();
                i++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        int n, seen_en, seen_p;
        bit found;
        RESET = 1; tsf = '0; in_valid = 0; ctrl = '0;
        trig_ts_hi = '0; trig_ts_lo = '0; burst_len = '0; tsf_run = 0;
        tick();
        tick();
        chk("rst_status", status, 0);
        chk("rst_left", samples_left, 0);
        chk("rst_en", samp_en, 0);
        chk("rst_pulse", trig_pulse, 0);
        RESET = 0;
        tick();

        // on-time burst
        tsf = 64'd900; tsf_run = 1; in_valid = 1;
        arm(64'd1000, 16, 0);
        wait_pulse(300, found);
        chk("ontime_found", found, 1);
        chk("ontime_pulse_tsf", tsf, 64'd1002);
        n = 0;
        while (samp_en && n < 100) begin
            n++;
            tick();
            if (n == 1) chk("ontime_pulse_width", trig_pulse, 0);
        end
        chk("ontime_len", n, 16);
        chk("ontime_status", status, 32'h0B);
        chk("ontime_left", samples_left, 0);
        tsf_run = 0;
        tick();

        // gapped valid
        tsf = 64'd2000; in_valid = 0;
        arm(64'd2000, 4, 0);
        wait_pulse(20, found);
        chk("gap_found", found, 1);
        n = 0;
        while (samp_en && n < 50) begin
            if (n % 2 == 0) chk("gap_left", samples_left, 4 - n / 2);
            in_valid = (n % 2 == 1);
            n++;
            tick();
        end
        chk("gap_len", n, 8);
        chk("gap_left_end", samples_left, 0);
        chk("gap_status", status, 32'h0B);

        // late arm
        tsf = 64'd5000; in_valid = 1;
        arm(64'd100, 4, 0);
        seen_en = 0; seen_p = 0;
        for (int i = 0; i < 10; i++) begin
            if (samp_en) seen_en++;
            if (trig_pulse) seen_p++;
            tick();
        end
`ifdef VITA49_TRIG_LATE_START_EN
        chk("late_pulses", seen_p, 1);
        chk("late_en_cycles", seen_en, 4);
        chk("late_status", status, 32'h0F);
`else
        chk("late_pulses", seen_p, 0);
        chk("late_en_cycles", seen_en, 0);
        chk("late_status", status, 32'h07);
`endif

        // continuous plus abort
        tsf = 64'd150; tsf_run = 1; in_valid = 1;
        arm(64'd200, 5, 1);
        wait_pulse(100, found);
        chk("cont_found", found, 1);
        chk("cont_pulse_tsf", tsf, 64'd202);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (samp_en) n++;
            tick();
        end
        chk("cont_en_cycles", n, 1000);
        chk("cont_left", samples_left, 5);
        chk("cont_state", status[1:0], 2);
        ctrl = 32'h2;
        tick();
        chk("abort_en_n1", samp_en, 1);
        tick();
        chk("abort_en_n2", samp_en, 0);
        chk("abort_state", status[1:0], 0);
        ctrl = '0; tsf_run = 0;
        tick();
        tick();

        // zero length
        tsf = 64'd3000;
        arm(64'd3000, 0, 0);
        seen_en = 0; seen_p = 0;
        for (int i = 0; i < 8; i++) begin
            if (samp_en) seen_en++;
            if (trig_pulse) seen_p++;
            tick();
        end
        chk("zero_pulses", seen_p, 1);
        chk("zero_en_cycles", seen_en, 0);
        chk("zero_state", status[1:0], 3);

        // re-arm during RUN is ignored
        tsf = 64'd4000; in_valid = 0;
        arm(64'd4000, 10, 0);
        wait_pulse(10, found);
        chk("rearm_found", found, 1);
        tick();
        tick();
        arm(64'd4500, 3, 0);
        tick();
        chk("rearm_state", status[1:0], 2);
        chk("rearm_left", samples_left, 10);
        in_valid = 1;
        n = 0;
        while (samp_en && n < 50) begin
            n++;
            tick();
        end
        chk("rearm_len", n, 10);

        // asynchronous reset mid-RUN
        in_valid = 0; tsf = 64'd6000;
        arm(64'd6000, 7, 0);
        wait_pulse(10, found);
        chk("arst_found", found, 1);
        chk("arst_left_before", samples_left, 7);
        chk("arst_en_before", samp_en, 1);
        #1 RESET = 1;
        #1;
        chk("arst_en", samp_en, 0);
        chk("arst_status", status, 0);
        chk("arst_left", samples_left, 0);
        chk("arst_pulse", trig_pulse, 0);
        tick();
        RESET = 0;
        tick();
        chk("post_rst_status", status, 0);
        chk("post_rst_left", samples_left, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
